// File: rtl/rf_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter: index/word widths, FIFO entry, FSM states.
// No logic here; imported by the interface, the result FIFO and the arbiter top.
package rf_write_arbiter_pkg;

  localparam int REG_W  = 5;
  localparam int WORD_W = 32;
  localparam int NREGS  = 1 << REG_W;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam reg_idx_t REG_ZERO = '0;

  typedef struct packed {
    reg_idx_t dest;
    word_t    data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_REQ    = 2'd1,
    ST_DRAIN  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of WriteBack request, long-unit result handshake and register-file write port.
// slave = arbiter side, master = surrounding pipeline / long unit / register file.
interface rf_write_arbiter_if;
  import rf_write_arbiter_pkg::*;

  logic             wb_write;
  reg_idx_t         wb_dest;
  word_t            wb_data;
  logic             lu_valid;
  reg_idx_t         lu_dest;
  word_t            lu_data;
  logic             lu_ready;
  logic             rf_write;
  reg_idx_t         rf_dest;
  word_t            rf_data;
  logic [NREGS-1:0] pending_mask;
  logic             pipe_stall;

  modport slave (
    input  wb_write, wb_dest, wb_data, lu_valid, lu_dest, lu_data,
    output lu_ready, rf_write, rf_dest, rf_data, pending_mask, pipe_stall
  );

  modport master (
    output wb_write, wb_dest, wb_data, lu_valid, lu_dest, lu_data,
    input  lu_ready, rf_write, rf_dest, rf_data, pending_mask, pipe_stall
  );

endinterface

// File: rtl/rf_write_arbiter_result_fifo.sv
// DEPTH-entry FIFO of {dest,data} long-unit results; head readable combinationally, 1-cycle push-to-head.
// Push while full and pop while empty are ignored; per-entry valid/dest exposed for pending-mask build.
module rf_result_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output entry_t           head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [PW-1:0]    head_idx,
  output logic [DEPTH-1:0] ent_vld,
  output reg_idx_t         ent_dest [DEPTH]
);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    // A push never lands on the slot being popped: push is blocked when full.
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign head_idx = rd_ptr_q;
  assign count    = count_q;
  assign ent_vld  = vld_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_dest[i] = mem_q[i].dest;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Owns the RF write port: WB wins combinationally, buffered long-unit results drain in idle WB slots.
// lu_ready = !full (no bypass); starved FIFO raises registered pipe_stall to force a WB bubble.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  rf_write_arbiter_if.slave bus
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int SW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  entry_t           push_entry, head;
  logic             fifo_full, fifo_empty;
  logic [CNTW-1:0]  fifo_count;
  logic [PW-1:0]    head_idx;
  logic [DEPTH-1:0] ent_vld;
  reg_idx_t         ent_dest [DEPTH];
  logic             wb_req, push, pop, fifo_drains;
  logic [SW-1:0]    starve_cnt_q, starve_cnt_d;
  logic [NREGS-1:0] pending_mask_q, pending_mask_d;
  arb_state_e       state_q;
  logic             pipe_stall_q;

  assign wb_req      = bus.wb_write && (bus.wb_dest != REG_ZERO);
  // Results for r0 complete the handshake but are dropped on the floor.
  assign push        = bus.lu_valid && !fifo_full && (bus.lu_dest != REG_ZERO);
  assign pop         = !wb_req && !fifo_empty;
  assign fifo_drains = pop && !push && (fifo_count == CNTW'(1));
  assign push_entry  = '{dest: bus.lu_dest, data: bus.lu_data};

  rf_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .head_idx   (head_idx),
    .ent_vld    (ent_vld),
    .ent_dest   (ent_dest)
  );

  assign bus.lu_ready     = !fifo_full;
  assign bus.rf_write     = rst_n && (wb_req || !fifo_empty);
  assign bus.rf_dest      = wb_req ? bus.wb_dest : head.dest;
  assign bus.rf_data      = wb_req ? bus.wb_data : head.data;
  assign bus.pending_mask = pending_mask_q;
  assign bus.pipe_stall   = pipe_stall_q;

  always_comb begin
    if (fifo_empty || pop) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Mask describes post-edge contents: surviving entries plus the incoming one.
  always_comb begin
    pending_mask_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && !(pop && (head_idx == PW'(i)))) pending_mask_d[ent_dest[i]] = 1'b1;
    end
    if (push) pending_mask_d[bus.lu_dest] = 1'b1;
    pending_mask_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q   <= '0;
      pending_mask_q <= '0;
    end else begin
      starve_cnt_q   <= starve_cnt_d;
      pending_mask_q <= pending_mask_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_NORMAL;
      pipe_stall_q <= 1'b0;
    end else begin
      case (state_q)
        ST_NORMAL: begin
          if (starve_cnt_d == LIMIT) begin
            state_q      <= ST_REQ;
            pipe_stall_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (fifo_drains) begin
            state_q      <= ST_NORMAL;
            pipe_stall_q <= 1'b0;
          end else begin
            state_q      <= ST_DRAIN;
            pipe_stall_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // A WB write here is a protocol violation; WB still wins and we keep waiting.
          if (pop) begin
            state_q      <= ST_NORMAL;
            pipe_stall_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_NORMAL;
          pipe_stall_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: queue-based reference model checked every negedge,
// plus hand-computed literal expectations along the directed sequence.
module tb_rf_write_arbiter;
  import rf_write_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  rf_write_arbiter_if bus ();

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO contents as a queue, starvation as a plain count,
  // phase 0=normal 1=bubble requested 2=draining.
  entry_t      m_q[$];
  int          m_cnt   = 0;
  int          m_phase = 0;
  logic        m_stall = 1'b0;
  logic [31:0] m_mask  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic   wbreq, pop;
    int     pre_size;
    entry_t e;
    if (!rst_n) begin
      m_q.delete();
      m_cnt   = 0;
      m_phase = 0;
      m_stall = 1'b0;
      m_mask  = '0;
      return;
    end
    wbreq    = bus.wb_write && (bus.wb_dest != 5'd0);
    pre_size = m_q.size();
    pop      = !wbreq && (pre_size > 0);
    if (pre_size == 0 || pop) m_cnt = 0;
    else if (m_cnt < LIMIT) m_cnt = m_cnt + 1;
    if (pop) void'(m_q.pop_front());
    if (bus.lu_valid && pre_size < DEPTH && bus.lu_dest != 5'd0) begin
      e.dest = bus.lu_dest;
      e.data = bus.lu_data;
      m_q.push_back(e);
    end
    case (m_phase)
      0:       if (m_cnt == LIMIT) m_phase = 1;
      1:       m_phase = (m_q.size() == 0) ? 0 : 2;
      default: if (pop) m_phase = 0;
    endcase
    m_stall = (m_phase != 0);
    m_mask  = '0;
    foreach (m_q[i]) m_mask[m_q[i].dest] = 1'b1;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Per-cycle compare against the model.
  initial forever begin
    logic        wbreq, exp_wr;
    logic [4:0]  exp_dest;
    logic [31:0] exp_data;
    @(negedge clk);
    wbreq    = bus.wb_write && (bus.wb_dest != 5'd0);
    exp_wr   = rst_n && (wbreq || m_q.size() > 0);
    exp_dest = bus.wb_dest;
    exp_data = bus.wb_data;
    if (!wbreq && m_q.size() > 0) begin
      exp_dest = m_q[0].dest;
      exp_data = m_q[0].data;
    end
    if (rst_n && m_phase == 2 && wbreq)
      $display("NOTE protocol violation: WB write during drain at t=%0t", $time);
    chk("cyc_lu_ready", 64'(bus.lu_ready), 64'(m_q.size() < DEPTH));
    chk("cyc_rf_write", 64'(bus.rf_write), 64'(exp_wr));
    if (exp_wr) begin
      chk("cyc_rf_dest", 64'(bus.rf_dest), 64'(exp_dest));
      chk("cyc_rf_data", 64'(bus.rf_data), 64'(exp_data));
    end
    chk("cyc_mask", 64'(bus.pending_mask), 64'(m_mask));
    chk("cyc_stall", 64'(bus.pipe_stall), 64'(m_stall));
  end

  task automatic drive(input logic wbw, input logic [4:0] wbd, input logic [31:0] wbdat,
                       input logic luv, input logic [4:0] lud, input logic [31:0] ludat);
    bus.wb_write = wbw;
    bus.wb_dest  = wbd;
    bus.wb_data  = wbdat;
    bus.lu_valid = luv;
    bus.lu_dest  = lud;
    bus.lu_data  = ludat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #3;
    chk("rst_lu_ready", 64'(bus.lu_ready), 64'd1);
    chk("rst_stall", 64'(bus.pipe_stall), 64'd0);
    chk("rst_mask", 64'(bus.pending_mask), 64'd0);
    chk("rst_rf_write", 64'(bus.rf_write), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // WB write passes straight through
    drive(1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    #2;
    chk("wb_rf_write", 64'(bus.rf_write), 64'd1);
    chk("wb_rf_dest", 64'(bus.rf_dest), 64'd8);
    chk("wb_rf_data", 64'(bus.rf_data), 64'hDEADBEEF);
    chk("wb_lu_ready", 64'(bus.lu_ready), 64'd1);
    chk("wb_mask", 64'(bus.pending_mask), 64'd0);
    tick();

    // single long-unit result drains in an idle WB slot
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'd42);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2;
    chk("lu1_mask", 64'(bus.pending_mask), 64'h8);
    chk("lu1_rf_write", 64'(bus.rf_write), 64'd1);
    chk("lu1_rf_dest", 64'(bus.rf_dest), 64'd3);
    chk("lu1_rf_data", 64'(bus.rf_data), 64'd42);
    tick();
    #2;
    chk("lu1_mask_after", 64'(bus.pending_mask), 64'd0);
    chk("lu1_idle", 64'(bus.rf_write), 64'd0);

    // starvation: two pushes under continuous WB traffic
    drive(1'b1, 5'd1, 32'h1111, 1'b1, 5'd5, 32'h55);
    tick();
    drive(1'b1, 5'd1, 32'h1112, 1'b1, 5'd6, 32'h66);
    tick();
    drive(1'b1, 5'd1, 32'h1113, 1'b0, 5'd0, 32'd0);
    #2;
    chk("st_full", 64'(bus.lu_ready), 64'd0);
    chk("st_wb_wins", 64'(bus.rf_dest), 64'd1);
    tick();
    tick();
    #2;
    chk("st_no_stall_yet", 64'(bus.pipe_stall), 64'd0);
    tick();
    #2;
    chk("st_stall_req", 64'(bus.pipe_stall), 64'd1);
    chk("st_mask_both", 64'(bus.pending_mask), 64'h60);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2;
    chk("st_drain_stall", 64'(bus.pipe_stall), 64'd1);
    chk("st_drain_dest", 64'(bus.rf_dest), 64'd5);
    chk("st_drain_data", 64'(bus.rf_data), 64'h55);
    tick();
    #2;
    chk("st_back_normal", 64'(bus.pipe_stall), 64'd0);
    chk("st_mask_6", 64'(bus.pending_mask), 64'h40);
    chk("st_ready_again", 64'(bus.lu_ready), 64'd1);
    tick();
    #2;
    chk("st_empty_mask", 64'(bus.pending_mask), 64'd0);

    // r0 result: accepted and discarded
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77);
    #2;
    chk("r0_ready", 64'(bus.lu_ready), 64'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2;
    chk("r0_mask", 64'(bus.pending_mask), 64'd0);
    chk("r0_no_write", 64'(bus.rf_write), 64'd0);
    tick();

    // full FIFO popping while lu_valid: no bypass, order kept
    drive(1'b1, 5'd2, 32'h2222, 1'b1, 5'd10, 32'hA0);
    tick();
    drive(1'b1, 5'd2, 32'h2223, 1'b1, 5'd11, 32'hB0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0);
    #2;
    chk("fp_not_ready", 64'(bus.lu_ready), 64'd0);
    chk("fp_head_first", 64'(bus.rf_dest), 64'd10);
    tick();
    #2;
    chk("fp_ready_next", 64'(bus.lu_ready), 64'd1);
    chk("fp_second", 64'(bus.rf_data), 64'hB0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2;
    chk("fp_third", 64'(bus.rf_data), 64'hC0);
    chk("fp_mask", 64'(bus.pending_mask), 64'h1000);
    tick();

    // reset with two entries buffered and a bubble requested
    drive(1'b1, 5'd4, 32'h4444, 1'b1, 5'd20, 32'h200);
    tick();
    drive(1'b1, 5'd4, 32'h4445, 1'b1, 5'd21, 32'h210);
    tick();
    drive(1'b1, 5'd4, 32'h4446, 1'b0, 5'd0, 32'd0);
    tick();
    tick();
    tick();
    #2;
    chk("mr_stall_pre", 64'(bus.pipe_stall), 64'd1);
    chk("mr_mask_pre", 64'(bus.pending_mask), 64'h0030_0000);
    rst_n = 1'b0;
    #1;
    chk("mr_mask", 64'(bus.pending_mask), 64'd0);
    chk("mr_stall", 64'(bus.pipe_stall), 64'd0);
    chk("mr_ready", 64'(bus.lu_ready), 64'd1);
    chk("mr_rf_write", 64'(bus.rf_write), 64'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    #2;
    chk("post_rst_idle", 64'(bus.rf_write), 64'd0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single register-file write port.
- Arbitrates between the in-order WriteBack stage (rf_dest/rf_data/rf_write) and a long-latency unit (mul/div) that returns results out of band via valid/ready.
- Buffers long-unit results in a small FIFO and publishes a pending-destination mask to the hazard unit.
- Requests a pipeline bubble when buffered results have starved too long.

Parameters:
- DEPTH, 2, long-unit result FIFO entries; power of two, >= 2.
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may be denied the port before a bubble is requested; >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_write  in  1  WriteBack write request.
- wb_dest  in  5  WriteBack destination register.
- wb_data  in  32  WriteBack data.
- lu_valid  in  1  long-unit result valid.
- lu_dest  in  5  long-unit destination register.
- lu_data  in  32  long-unit result.
- lu_ready  out  1  FIFO can accept; equals !full.
- rf_write  out  1  register-file write enable.
- rf_dest  out  5  register-file write address.
- rf_data  out  32  register-file write data.
- pending_mask  out  32  bit r set while any FIFO entry targets r; bit 0 is always 0.
- pipe_stall  out  1  registered bubble request to the hazard unit.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty; read/write pointers 0; starve counter 0; FSM=NORMAL.
  - lu_ready=1, pipe_stall=0, pending_mask=0.
  - rf_write is forced to 0 while rst_n=0.
- Enqueue:
  - Fires on lu_valid && lu_ready.
  - lu_dest==0 is accepted (handshake completes) but discarded: no FIFO entry, no mask bit.
- Port grant (combinational, same cycle):
  - wb_write && wb_dest!=0: WB wins; rf_* = wb_*.
  - Else if FIFO non-empty: the head drains; rf_* = head; pop at the clock edge.
  - Else rf_write=0.
  - wb_write with wb_dest==0 counts as no request. rf_dest/rf_data are don't-care when rf_write=0.
- WB always has priority, in every FSM state; WB is never stalled by this block in the same cycle.
- Simultaneous push and pop: both take effect; count is unchanged. Push when full is impossible (lu_ready=0). Pointers wrap modulo DEPTH.
- Full FIFO with a pop in the same cycle:
  - lu_ready stays 0 that cycle; there is no same-cycle bypass.
  - lu_ready rises the next cycle.
- pending_mask:
  - Registered; reflects the FIFO contents after the edge.
  - An entry being popped clears its bit only if no other remaining entry shares the dest.
  - The hazard unit uses it to stall readers and WAW issues.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle the FIFO is non-empty and not popped.
  - Clears on any pop or when the FIFO is empty.
- FSM:
  - NORMAL: when the counter reaches STARVE_LIMIT at an edge, go to REQ.
  - REQ: pipe_stall=1. The hazard unit freezes upstream, so WB presents a bubble next cycle. Go to DRAIN.
  - DRAIN: pipe_stall=1; the head pops (WB idle by contract). Return to NORMAL after one pop.
  - If the FIFO empties in REQ (WB happened to idle), skip DRAIN and go to NORMAL.
- If WB still requests in DRAIN (protocol violation), WB wins, the FSM stays in DRAIN, and the bench flags it.
- Mid-operation reset (rst_n falls) discards all buffered results immediately; the long unit must be reset by the same rst_n.

Decomposition:
- Shared package / defines: register-index width (5), word width (32), REG_ZERO constant, and the FSM state encoding for NORMAL/REQ/DRAIN.
- Natural sub-module: rf_result_fifo (parameterised DEPTH FIFO holding {dest,data}, exposing head, full, empty, per-entry valid and dest for mask generation).
- Arbitration, counter and FSM stay in rf_write_arbiter.

Test Plan:
- Reset, idle, then wb_write=1 wb_dest=8 wb_data=0xDEADBEEF -> same cycle rf_write=1 rf_dest=8 rf_data=0xDEADBEEF; lu_ready=1; pending_mask=0.
- WB idle, lu_valid=1 lu_dest=3 lu_data=42 for one cycle -> pending_mask=0x8 next cycle, rf_write=1 rf_dest=3 rf_data=42, pending_mask=0 after the pop.
- Two lu pushes (dest 5, dest 6) while WB writes every cycle -> lu_ready=0 after the second push; after 4 denied cycles pipe_stall=1; WB drops to 0; dest 5 drains in DRAIN; FSM back to NORMAL; dest 6 remains pending (mask=0x40).
- lu_valid=1 lu_dest=0 -> handshake completes, FIFO stays empty, pending_mask=0, no rf_write.
- FIFO full with the head popping while lu_valid=1 -> no accept that cycle; accepted next cycle; order preserved (first-in written first).
- Assert rst_n=0 with 2 entries buffered and pipe_stall=1 -> immediately pending_mask=0, pipe_stall=0, lu_ready=1, rf_write=0.
